// File: rtl/dmem_pkg.sv
// Shared encodings and the access-legality check for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  // limit is the region size in bytes; 33 bits so a full 4 GiB window still fits.
  // Addresses below base wrap to huge offsets and fail the range check.
  function automatic logic access_err(input logic [31:0] addr,
                                      input logic [1:0]  size,
                                      input logic [31:0] base,
                                      input logic [32:0] limit);
    logic [31:0] off;
    logic        bad_size;
    logic        misaligned;
    logic        out_of_range;
    off          = addr - base;
    bad_size     = (size == 2'b11);
    misaligned   = ((size == SZ_H) && addr[0]) ||
                   ((size == SZ_W) && (addr[1:0] != 2'b00));
    out_of_range = ({1'b0, off} >= limit);
    return bad_size || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/dmem_sram_be.sv
// Word-wide synchronous array: byte-enabled write, one-cycle registered read.
// Contents are deliberately not reset.
module dmem_sram_be #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's load/store port: req/ack handshake with programmable
// wait states, byte/half/word lanes, load extension and access-error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic          capture;
  logic          err;
  logic [31:0]   off_i;
  logic [31:0]   off_q;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_val;

  // The ack cycle is spent in IDLE but may not capture, which guarantees one
  // clean IDLE cycle between an ack and the next request.
  assign capture = (state == IDLE) && req_i && !ack_o;
  assign off_i   = addr_i - BASE_ADDR;
  assign off_q   = addr_q - BASE_ADDR;
  assign err     = access_err(addr_q, size_q, BASE_ADDR, LIMIT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (capture) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (capture) begin
        cnt     <= CNT_INIT;
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        size_q  <= size_i;
        uns_q   <= unsigned_i;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Read is launched on the edge entering RESP; with no wait states that edge
  // is the capture edge, so the live address is used there.
  assign rd_en  = (state_nx == RESP);
  assign rd_idx = (state == IDLE) ? AW'(off_i >> 2) : AW'(off_q >> 2);

  assign wr_en = (state == RESP) && we_q && !err;

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = wdata_q;
    case (size_q)
      SZ_B: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  dmem_sram_be #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_word),
    .wr_en   (wr_en),
    .wr_idx  (AW'(off_q >> 2)),
    .wr_be   (wr_be),
    .wr_data (wr_data)
  );

  assign byte_v = 8'(rd_word >> {addr_q[1:0], 3'b000});
  assign half_v = 16'(rd_word >> {addr_q[1], 4'b0000});

  always_comb begin
    load_val = rd_word;
    case (size_q)
      SZ_B:    load_val = uns_q ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_H:    load_val = uns_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      ack_o   <= (state == RESP);
      err_o   <= (state == RESP) && err;
      rdata_o <= ((state == RESP) && !err && !we_q) ? load_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states at base 0, no wait
// states at base 0x1000) checked against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam logic [1:0]  SZ_B   = 2'b00;
  localparam logic [1:0]  SZ_H   = 2'b01;
  localparam logic [1:0]  SZ_W   = 2'b10;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_req = 0, a_we = 0, a_uns = 0;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic [1:0]  a_size = 0;
  logic        a_ack, a_err;
  logic [31:0] a_rdata;

  logic        b_req = 0, b_we = 0, b_uns = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic [1:0]  b_size = 0;
  logic        b_ack, b_err;
  logic [31:0] b_rdata;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [7:0] mem_a [int unsigned];
  logic [7:0] mem_b [int unsigned];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .rst(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .size_i(a_size), .unsigned_i(a_uns),
    .ack_o(a_ack), .err_o(a_err), .rdata_o(a_rdata));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .size_i(b_size), .unsigned_i(b_uns),
    .ack_o(b_ack), .err_o(b_err), .rdata_o(b_rdata));

  // ---------------- reference model ----------------
  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size,
                                   input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return (size == 2'b11) || (size == SZ_H && addr % 2 != 0) ||
           (size == SZ_W && addr % 4 != 0) || (off >= 32'd4096);
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
  endfunction

  task automatic model_store(input int sel, input logic [31:0] off,
                             input logic [31:0] wdata, input logic [1:0] size);
    for (int i = 0; i < nbytes(size); i++) begin
      if (sel == 0) mem_a[off + i] = 8'(wdata >> (8 * i));
      else          mem_b[off + i] = 8'(wdata >> (8 * i));
    end
  endtask

  task automatic model_load(input int sel, input logic [31:0] off, input logic [1:0] size,
                            input bit uns, output logic [31:0] val, output bit known);
    longint v;
    int nb;
    nb = nbytes(size);
    v = 0;
    known = 1;
    for (int i = 0; i < nb; i++) begin
      if (sel == 0 && mem_a.exists(off + i)) v = v + (longint'(mem_a[off + i]) << (8 * i));
      else if (sel != 0 && mem_b.exists(off + i)) v = v + (longint'(mem_b[off + i]) << (8 * i));
      else known = 0;
    end
    if (size != SZ_W && !uns && v >= (64'sd1 <<< (8 * nb - 1))) v = v - (64'sd1 <<< (8 * nb));
    val = 32'(v);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int sel, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    if (sel == 0) begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_size = size; a_uns = uns;
    end else begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_size = size; b_uns = uns;
    end
  endtask

  task automatic do_txn(input string tag, input int sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                        input bit drop_early);
    int n, lat;
    bit got, exp_err, known;
    logic [31:0] base, exp_rd, rd;
    logic er, ak;
    lat  = (sel == 0) ? 4 : 2;
    base = (sel == 0) ? BASE_A : BASE_B;
    exp_err = model_err(addr, size, base);
    drive(sel, 1'b1, we, addr, wdata, size, uns);
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && drop_early) drive(sel, 1'b0, ~we, $urandom, $urandom, 2'($urandom), ~uns);
      got = (sel == 0) ? a_ack : b_ack;
    end
    rd = (sel == 0) ? a_rdata : b_rdata;
    er = (sel == 0) ? a_err : b_err;
    drive(sel, 1'b0, we, addr, wdata, size, uns);
    cmp_cnt++;
    if (!got || n != lat) begin
      err_cnt++;
      $display("FAIL %s latency: got %0d cycles (acked=%0b), required %0d", tag, n, got, lat);
    end
    if (got) begin
      cmp_cnt++;
      if (er !== exp_err) begin
        err_cnt++;
        $display("FAIL %s err: got %b, required %b", tag, er, exp_err);
      end
      known = 1;
      exp_rd = 32'd0;
      if (!exp_err && !we) model_load(sel, addr - base, size, uns, exp_rd, known);
      if (known) begin
        cmp_cnt++;
        if (rd !== exp_rd) begin
          err_cnt++;
          $display("FAIL %s rdata: got %h, required %h", tag, rd, exp_rd);
        end
      end
      if (!exp_err && we) model_store(sel, addr - base, wdata, size);
    end
    @(posedge clk); #1;
    ak = (sel == 0) ? a_ack : b_ack;
    rd = (sel == 0) ? a_rdata : b_rdata;
    er = (sel == 0) ? a_err : b_err;
    cmp_cnt++;
    if (ak !== 1'b0 || er !== 1'b0 || rd !== 32'd0) begin
      err_cnt++;
      $display("FAIL %s after_ack: got ack=%b err=%b rdata=%h, required 0/0/0", tag, ak, er, rd);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++;
    if ({a_ack, a_err, a_rdata, b_ack, b_err, b_rdata} !== 66'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got a=%b/%b/%h b=%b/%b/%h, required all 0",
               a_ack, a_err, a_rdata, b_ack, b_err, b_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    do_txn("st_word_10", 0, 1, 32'h10, 32'hDEAD_BEEF, SZ_W, 0, 0);
    do_txn("ld_word_10", 0, 0, 32'h10, 32'h0, SZ_W, 0, 0);
  endtask

  task automatic test_lanes();
    do_txn("st_byte_12", 0, 1, 32'h12, 32'h0000_005A, SZ_B, 0, 0);
    do_txn("ld_half_s_12", 0, 0, 32'h12, 32'h0, SZ_H, 0, 0);
    do_txn("ld_half_u_12", 0, 0, 32'h12, 32'h0, SZ_H, 1, 0);
    do_txn("ld_byte_s_13", 0, 0, 32'h13, 32'h0, SZ_B, 0, 0);
    do_txn("ld_byte_u_13", 0, 0, 32'h13, 32'h0, SZ_B, 1, 0);
    do_txn("ld_word_10b", 0, 0, 32'h10, 32'h0, SZ_W, 1, 0);
    do_txn("st_half_hi_10", 0, 1, 32'h12, 32'hFFFF_8123, SZ_H, 0, 0);
    do_txn("ld_word_10c", 0, 0, 32'h10, 32'h0, SZ_W, 0, 0);
  endtask

  task automatic test_errors();
    do_txn("st_word_14", 0, 1, 32'h14, 32'h0123_4567, SZ_W, 0, 0);
    do_txn("ld_half_11", 0, 0, 32'h11, 32'h0, SZ_H, 0, 0);
    do_txn("st_word_16", 0, 1, 32'h16, 32'hFFFF_FFFF, SZ_W, 0, 0);
    do_txn("ld_word_14", 0, 0, 32'h14, 32'h0, SZ_W, 0, 0);
    do_txn("ld_oor_1000", 0, 0, 32'h1000, 32'h0, SZ_W, 0, 0);
    do_txn("st_oor_1000", 0, 1, 32'h1000, 32'h5555_5555, SZ_W, 0, 0);
    do_txn("ld_size11", 0, 0, 32'h0, 32'h0, 2'b11, 0, 0);
    do_txn("st_word_ffc", 0, 1, 32'hFFC, 32'h8765_4321, SZ_W, 0, 0);
    do_txn("ld_word_ffc", 0, 0, 32'hFFC, 32'h0, SZ_W, 0, 0);
    do_txn("b_below_base", 1, 0, BASE_B - 4, 32'h0, SZ_W, 0, 0);
    do_txn("b_ld_top", 1, 0, BASE_B + 32'hFFC, 32'h0, SZ_W, 0, 0);
  endtask

  task automatic test_drop_early();
    do_txn("b_st_drop", 1, 1, BASE_B + 32'h8, 32'hA5C3_0F96, SZ_W, 0, 1);
    do_txn("b_ld_drop", 1, 0, BASE_B + 32'h9, 32'h0, SZ_B, 0, 1);
    do_txn("a_ld_drop", 0, 0, 32'h14, 32'h0, SZ_H, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    bit known;
    model_load(1, 32'h8, SZ_W, 0, exp_rd, known);
    drive(1, 1'b1, 1'b0, BASE_B + 32'h8, 32'h0, SZ_W, 1'b0);
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (b_ack !== (n % 3 == 2)) begin
        err_cnt++;
        $display("FAIL b2b_ack cycle %0d: got %b, required %b", n, b_ack, (n % 3 == 2));
      end
      if (b_ack === 1'b1) begin
        cmp_cnt++;
        if (b_rdata !== exp_rd || b_err !== 1'b0) begin
          err_cnt++;
          $display("FAIL b2b_data cycle %0d: got %h err=%b, required %h err=0", n, b_rdata, b_err, exp_rd);
        end
      end
      if (n == 8) b_req = 1'b0;
    end
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (b_ack !== 1'b0) begin
        err_cnt++;
        $display("FAIL b2b_tail cycle %0d: got ack %b, required 0", n, b_ack);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_txn("st_word_20", 0, 1, 32'h20, 32'hCAFE_F00D, SZ_W, 0, 0);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, SZ_W, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if ({a_ack, a_err, a_rdata} !== 34'd0) begin
      err_cnt++;
      $display("FAIL rst_mid_outputs: got %b/%b/%h, required 0/0/0", a_ack, a_err, a_rdata);
    end
    drive(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, SZ_W, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a_ack !== 1'b0) seen = 1;
    end
    cmp_cnt++;
    if (seen) begin
      err_cnt++;
      $display("FAIL rst_mid_noack: got ack after reset, required none");
    end
    do_txn("ld_word_20", 0, 0, 32'h20, 32'h0, SZ_W, 0, 0);
  endtask

  task automatic test_random();
    int sel, r, w;
    logic [31:0] base, addr;
    for (int i = 0; i < 20; i++) begin
      w = (i < 16) ? i : 1004 + i;
      do_txn("rnd_init_a", 0, 1, BASE_A + 32'(w * 4), $urandom, SZ_W, 0, 0);
      do_txn("rnd_init_b", 1, 1, BASE_B + 32'(w * 4), $urandom, SZ_W, 0, 0);
    end
    for (int i = 0; i < 120; i++) begin
      sel  = i % 2;
      base = (sel == 0) ? BASE_A : BASE_B;
      r    = $urandom_range(0, 9);
      if (r == 0) addr = $urandom;
      else begin
        w    = (r < 6) ? $urandom_range(0, 15) : $urandom_range(1020, 1023);
        addr = base + 32'(w * 4) + 32'($urandom_range(0, 3));
      end
      do_txn("rnd", sel, 1'($urandom_range(0, 1)), addr, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_drop_early();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
